// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM state encodings,
// bubble encoding and the opcodes the static predictor recognises.
package ifu_pkg;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_FULL = 3'd3,
    ST_DROP = 3'd4
  } ifu_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [63:0] PC_STEP    = 64'd4;

endpackage

// File: rtl/ifu_static_pred.sv
// Combinational static next-PC guess: JAL target, backward-taken/forward-not-taken
// for conditional branches, pc+4 otherwise.
module ifu_static_pred
  import ifu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [63:0] pc,
  output logic [63:0] snxt
);

  logic [63:0] imm_j;
  logic [63:0] imm_b;

  // Decode J/B immediates and pick the static next PC
  always_comb begin
    imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    snxt  = pc + PC_STEP;
    case (instr[6:0])
      OPC_JAL: snxt = pc + imm_j;
      OPC_BRANCH: begin
        if (instr[31] == 1'b1) begin
          snxt = pc + imm_b;
        end else begin
          snxt = pc + PC_STEP;
        end
      end
      default: snxt = pc + PC_STEP;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: single-outstanding imem requests, skid on load-hazard stall,
// flush/redirect handling. Define IFU_STATIC_PREDICT_EN to enable the static predictor.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ld_hz_stall,
  input  logic        flush_en,
  input  logic [63:0] flush_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifu_valid,
  output logic [31:0] ifu_instr,
  output logic [63:0] ifu_pc,
  output logic [63:0] ifu_snxt_pc
);

  import ifu_pkg::*;

  ifu_state_e  state;
  ifu_state_e  state_nxt;
  logic [63:0] fetch_pc;
  logic [63:0] fetch_pc_nxt;
  logic [31:0] skid;
  logic [31:0] skid_nxt;
  logic        load;
  logic [31:0] load_instr;
  logic [63:0] snxt;

  assign imem_req  = (state == ST_REQ);
  assign imem_addr = fetch_pc;

`ifdef IFU_STATIC_PREDICT_EN
  ifu_static_pred u_pred (
    .instr (load_instr),
    .pc    (fetch_pc),
    .snxt  (snxt)
  );
`else
  assign snxt = fetch_pc + PC_STEP;
`endif

  // Next-state, skid and fetch-PC update
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    skid_nxt     = skid;
    load         = 1'b0;
    load_instr   = imem_rdata;
    case (state)
      ST_BOOT: state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_ready) begin
          state_nxt = flush_en ? ST_DROP : ST_WAIT;
        end else begin
          state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (flush_en) begin
          // a response arriving with the flush is stale; otherwise it is still in flight
          state_nxt = imem_rvalid ? ST_REQ : ST_DROP;
        end else if (imem_rvalid && ld_hz_stall) begin
          skid_nxt  = imem_rdata;
          state_nxt = ST_FULL;
        end else if (imem_rvalid) begin
          load      = 1'b1;
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_FULL: begin
        load_instr = skid;
        if (flush_en) begin
          skid_nxt  = NOP_INSTR;
          state_nxt = ST_REQ;
        end else if (!ld_hz_stall) begin
          load      = 1'b1;
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_FULL;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_nxt = ST_REQ;
        end else begin
          state_nxt = ST_DROP;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase

    if (flush_en) begin
      fetch_pc_nxt = flush_pc;
    end else if (load) begin
      fetch_pc_nxt = snxt;
    end else begin
      fetch_pc_nxt = fetch_pc;
    end
  end

  // FSM, fetch PC and skid registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
      skid     <= NOP_INSTR;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      skid     <= skid_nxt;
    end
  end

  // IFU->IDU output registers: flush beats stall, stall beats new data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifu_valid   <= 1'b0;
      ifu_instr   <= NOP_INSTR;
      ifu_pc      <= 64'd0;
      ifu_snxt_pc <= 64'd0;
    end else if (flush_en) begin
      ifu_valid <= 1'b0;
      ifu_instr <= NOP_INSTR;
    end else if (ld_hz_stall) begin
      ifu_valid <= ifu_valid;
      ifu_instr <= ifu_instr;
    end else if (load) begin
      ifu_valid   <= 1'b1;
      ifu_instr   <= load_instr;
      ifu_pc      <= fetch_pc;
      ifu_snxt_pc <= snxt;
    end else begin
      ifu_valid <= 1'b0;
      ifu_instr <= NOP_INSTR;
    end
  end

endmodule
